node_injector: RTL

//  Transmit side of a ring node: accepts local requests, packs them into the 32-bit ring

---
 rtl/node_injector.sv | 124 ++++++++++++
 1 files changed

// File: rtl/node_injector.sv
// Transmit side of a ring node: packs local requests into ring instructions, buffers them
// in a small FIFO and injects them into free ring slots, yielding to upstream traffic.
module node_injector #(
  parameter logic [2:0]  NODE_IP      = 3'b000,
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter int unsigned CNT_W        = 3,
  parameter int unsigned STARVE_LIMIT = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tx_valid,
  output logic             tx_ready,
  input  logic [2:0]       tx_dest,
  input  logic [25:0]      tx_payload,
  input  logic [31:0]      ring_instruction_in,
  input  logic             ring_enable_in,
  output logic [31:0]      ring_instruction_out,
  output logic             ring_enable_out,
  output logic             ring_bubble_req,
  output logic             self_drop,
  output logic [CNT_W-1:0] fifo_count
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned STV_W = 8;
  localparam int unsigned PKT_W = 32;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_INJECT,
    S_STARVED
  } state_t;

  state_t state, state_d;

  logic [PKT_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [STV_W-1:0] starve_cnt, starve_d;
  logic [CNT_W-1:0] count_d;
  logic             accept, is_self, push, pop;
  logic [PKT_W-1:0] pkt;

  // Ready depends only on the registered occupancy: a pop never frees a slot in the same cycle.
  assign tx_ready = (fifo_count < CNT_W'(FIFO_DEPTH));
  assign accept   = tx_valid & tx_ready;
  assign is_self  = (tx_dest == NODE_IP);
  assign push     = accept & ~is_self;
  assign pkt      = {tx_dest, NODE_IP, tx_payload};

  // Injection arbiter: IDLE tracks an empty FIFO, so any other state with a free slot pops.
  always_comb begin
    state_d  = state;
    pop      = 1'b0;
    starve_d = starve_cnt;
    count_d  = fifo_count;

    pop     = (state != S_IDLE) && !ring_enable_in;
    count_d = fifo_count + CNT_W'(push) - CNT_W'(pop);

    if (pop || (state == S_IDLE)) begin
      starve_d = '0;
    end else if (starve_cnt != STV_W'(STARVE_LIMIT)) begin
      starve_d = starve_cnt + STV_W'(1);
    end

    case (state)
      S_IDLE: begin
        if (push) state_d = S_WAIT;
      end
      default: begin
        if (count_d == '0) begin
          state_d = S_IDLE;
        end else if (starve_d == STV_W'(STARVE_LIMIT)) begin
          state_d = S_STARVED;
        end else if (pop) begin
          state_d = S_INJECT;
        end else begin
          state_d = S_WAIT;
        end
      end
    endcase
  end

  // FIFO storage needs no reset: occupancy and pointers define which entries are live.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= pkt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state                <= S_IDLE;
      wr_ptr               <= '0;
      rd_ptr               <= '0;
      fifo_count           <= '0;
      starve_cnt           <= '0;
      ring_instruction_out <= '0;
      ring_enable_out      <= 1'b0;
      ring_bubble_req      <= 1'b0;
      self_drop            <= 1'b0;
    end else begin
      state           <= state_d;
      fifo_count      <= count_d;
      starve_cnt      <= starve_d;
      ring_bubble_req <= (starve_cnt == STV_W'(STARVE_LIMIT));
      self_drop       <= accept & is_self;

      if (push) wr_ptr <= wr_ptr + PTR_W'(1);

      // Upstream traffic always wins the slot; otherwise the FIFO head takes it.
      if (ring_enable_in) begin
        ring_instruction_out <= ring_instruction_in;
        ring_enable_out      <= 1'b1;
      end else if (pop) begin
        ring_instruction_out <= mem[rd_ptr];
        ring_enable_out      <= 1'b1;
        rd_ptr               <= rd_ptr + PTR_W'(1);
      end else begin
        ring_enable_out      <= 1'b0;
      end
    end
  end

endmodule
